// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer, WIDTH bits per word, selectable bit order
// Defining SIPO_PARITY_EN adds a PARITY state that consumes a trailing even-parity bit per word.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       in_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       busy,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shifter_q, shifter_d;
  logic [WIDTH-1:0]  pout_q, pout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovalid_q, ovalid_d;
  logic [WIDTH-1:0]  shift_in;

  assign shift_in = MSB_FIRST ? {shifter_q[WIDTH-2:0], serial_in}
                              : {serial_in, shifter_q[WIDTH-1:1]};

`ifdef SIPO_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    pout_d    = pout_q;
    cnt_d     = cnt_q;
    ovalid_d  = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_d    = perr_q;
`endif
    // clear wins over in_valid; the bit offered alongside it is dropped
    if (clear) begin
      state_d   = IDLE;
      shifter_d = '0;
      cnt_d     = '0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          shifter_d = shift_in;
          cnt_d     = CW'(1);
          state_d   = SHIFT;
        end
        SHIFT: begin
          shifter_d = shift_in;
          if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
            cnt_d    = CW'(WIDTH);
            state_d  = PARITY;
`else
            pout_d   = shift_in;
            ovalid_d = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          pout_d   = shifter_q;
          ovalid_d = 1'b1;
          perr_d   = (^shifter_q) ^ serial_in;
          cnt_d    = '0;
          state_d  = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shifter_q <= '0;
      pout_q    <= '0;
      cnt_q     <= '0;
      ovalid_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      pout_q    <= pout_d;
      cnt_q     <= cnt_d;
      ovalid_q  <= ovalid_d;
`ifdef SIPO_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = ovalid_q;
  assign bit_cnt      = cnt_q;
  assign busy         = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser (WIDTH=4, both bit orders)
// Expected values come from a queue-of-accepted-bits reference model.
module tb_sipo_deser;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk, reset, serial_in, in_valid, clear;
  logic [W-1:0] pout_m, pout_l;
  logic         ov_m, ov_l, busy_m, busy_l, pe_m, pe_l;
  logic [2:0]   cnt_m, cnt_l;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .in_valid(in_valid), .clear(clear),
    .parallel_out(pout_m), .out_valid(ov_m), .bit_cnt(cnt_m), .busy(busy_m), .parity_err(pe_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .in_valid(in_valid), .clear(clear),
    .parallel_out(pout_l), .out_valid(ov_l), .bit_cnt(cnt_l), .busy(busy_l), .parity_err(pe_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int           bits[$];
  logic [W-1:0] e_m = '0, e_l = '0;
  logic         e_ov = 1'b0, e_pe = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic v, input logic b, input logic c);
    int par;
    e_ov = 1'b0;
    if (c) begin
      bits.delete();
    end else if (v) begin
      bits.push_back(int'(b));
      if (bits.size() == W + P) begin
        e_m = '0;
        e_l = '0;
        par = 0;
        for (int i = 0; i < W; i++) begin
          e_m = e_m | (W'(bits[i]) << (W - 1 - i));
          e_l = e_l | (W'(bits[i]) << i);
        end
        for (int i = 0; i < W + P; i++) par = par + bits[i];
        if (P == 1) e_pe = par[0];
        e_ov = 1'b1;
        bits.delete();
      end
    end
  endtask

  task automatic model_reset();
    bits.delete();
    e_m = '0; e_l = '0; e_ov = 1'b0; e_pe = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":pout_msb"}, 32'(pout_m), 32'(e_m));
    check({tag, ":pout_lsb"}, 32'(pout_l), 32'(e_l));
    check({tag, ":ovalid_m"}, 32'(ov_m), 32'(e_ov));
    check({tag, ":ovalid_l"}, 32'(ov_l), 32'(e_ov));
    check({tag, ":bit_cnt"}, 32'(cnt_m), 32'(bits.size()));
    check({tag, ":bit_cnt_l"}, 32'(cnt_l), 32'(bits.size()));
    check({tag, ":busy"}, 32'(busy_m), 32'(bits.size() != 0));
    check({tag, ":busy_l"}, 32'(busy_l), 32'(bits.size() != 0));
    check({tag, ":perr_m"}, 32'(pe_m), 32'(e_pe));
    check({tag, ":perr_l"}, 32'(pe_l), 32'(e_pe));
  endtask

  task automatic step(input string tag, input logic v, input logic b, input logic c);
    in_valid  = v;
    serial_in = b;
    clear     = c;
    @(posedge clk);
    model_update(v, b, c);
    #1;
    check_all(tag);
  endtask

  // sends w[W-1] first in time, then a parity bit when parity is built in
  task automatic word4(input string tag, input logic [W-1:0] w, input logic par);
    logic [W-1:0] wv;
    wv = w;
    for (int i = W - 1; i >= 0; i--) step(tag, 1'b1, wv[i], 1'b0);
    if (P == 1) step(tag, 1'b1, par, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ":rst_pout_m"}, 32'(pout_m), 32'd0);
    check({tag, ":rst_pout_l"}, 32'(pout_l), 32'd0);
    check({tag, ":rst_ovalid"}, 32'(ov_m), 32'd0);
    check({tag, ":rst_cnt"}, 32'(cnt_m), 32'd0);
    check({tag, ":rst_busy"}, 32'(busy_m), 32'd0);
    check({tag, ":rst_perr"}, 32'(pe_m), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; serial_in = 1'b0; in_valid = 1'b0; clear = 1'b0;
    #12;
    check_all("reset");
    check("reset:busy_const", 32'(busy_m), 32'd0);
    reset = 1'b0;

    // 1,0,1,1 -> MSB-first 1011, LSB-first 1101
    word4("w1011", 4'b1011, 1'b1);
    check("w1011:msb_const", 32'(pout_m), 32'hB);
    check("w1011:lsb_const", 32'(pout_l), 32'hD);
    check("w1011:ovalid_const", 32'(ov_m), 32'd1);
    check("w1011:cnt_const", 32'(cnt_m), 32'd0);
    step("after_w1011", 1'b0, 1'b0, 1'b0);
    check("after_w1011:ovalid_low", 32'(ov_m), 32'd0);

    // gap in the middle of a word
    step("gap", 1'b1, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("gap_idle", 1'b0, 1'b1, 1'b0);
      check("gap:busy_const", 32'(busy_m), 32'd1);
    end
    step("gap", 1'b1, 1'b0, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0);
    if (P == 1) step("gap_par", 1'b1, 1'b1, 1'b0);
    check("gap:msb_const", 32'(pout_m), 32'hD);

    // back-to-back words
    word4("b2b_a", 4'b1011, 1'b1);
    word4("b2b_b", 4'b0110, 1'b0);
    check("b2b:msb_const", 32'(pout_m), 32'h6);

    // clear mid-word, with a bit offered on the clear cycle
    step("clr", 1'b1, 1'b1, 1'b0);
    step("clr", 1'b1, 1'b0, 1'b0);
    step("clr_cyc", 1'b1, 1'b1, 1'b1);
    check("clr:pout_held", 32'(pout_m), 32'h6);
    word4("after_clr", 4'b0011, 1'b0);
    check("after_clr:msb_const", 32'(pout_m), 32'h3);

    // asynchronous reset mid-word
    step("pre_rst", 1'b1, 1'b1, 1'b0);
    step("pre_rst", 1'b1, 1'b1, 1'b0);
    async_reset("midword");
    word4("post_rst", 4'b1001, 1'b0);

`ifdef SIPO_PARITY_EN
    word4("par_ok", 4'b1011, 1'b1);
    check("par_ok:perr_const", 32'(pe_m), 32'd0);
    check("par_ok:msb_const", 32'(pout_m), 32'hB);
    word4("par_bad", 4'b1011, 1'b0);
    check("par_bad:perr_const", 32'(pe_m), 32'd1);
    check("par_bad:msb_const", 32'(pout_m), 32'hB);
    step("par_hold", 1'b1, 1'b1, 1'b1);
    check("par_hold:perr_clear", 32'(pe_m), 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 24) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
